dcache_memsys: RTL and testbench

Parametrised data-memory subsystem for the MEM stage of the pipeline: a direct-mapped, write-through, no-write-allocate data cache in front of a multi-cycle backing memory, with a refill state machine and a stall output. It generalises the fixed two-word-line cache/memory pair into configurable line count, line size and memory latency. On a read miss it holds the pipeline until the line is refilled.

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_memsys_dmem_backing.sv | 37 +++
 rtl/dcache_memsys.sv | 126 ++++++++++++
 tb/tb_dcache_memsys.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the dcache_memsys data-memory subsystem.
package dcache_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_LINES     = 16;
    localparam int DEF_WORDS     = 2;
    localparam int DEF_MEM_DEPTH = 1024;
    localparam int DEF_MEM_LAT   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines, input int words);
        return addr_w - 2 - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_memsys_dmem_backing.sv
// Backing word RAM: synchronous single-word write, combinational whole-line read.
module dmem_backing
    import dcache_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int WA_W      = DEF_ADDR_W - 2,
    parameter int WORDS     = DEF_WORDS,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [WA_W-1:0]               waddr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [WA_W-1:0]               raddr,
    output logic [WORDS-1:0][DATA_W-1:0]  rline
);

    localparam int MA_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [WA_W-1:0] DEPTH_V = WA_W'(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [WA_W-1:0]   wwrap;

    // Out-of-range word addresses alias back into the array.
    assign wwrap = waddr % DEPTH_V;

    always_ff @(posedge clk) begin
        if (we) mem[MA_W'(wwrap)] <= wdata;
    end

    for (genvar w = 0; w < WORDS; w++) begin : g_rd
        logic [WA_W-1:0] ra;
        assign ra       = (raddr + WA_W'(w)) % DEPTH_V;
        assign rline[w] = mem[MA_W'(ra)];
    end

endmodule

// File: rtl/dcache_memsys.sv
// Direct-mapped write-through no-write-allocate data cache with refill FSM.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_memsys
    import dcache_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LINES     = DEF_LINES,
    parameter int WORDS     = DEF_WORDS,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int MEM_LAT   = DEF_MEM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rden,
    input  logic              wren,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int WA_W  = ADDR_W - 2;
    localparam int OFF_W = off_w(WORDS);
    localparam int OFFX  = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS);
    localparam int CNT_W = ($clog2(MEM_LAT) > 0) ? $clog2(MEM_LAT) : 1;

    logic [WA_W-1:0]  word_addr, line_base;
    logic [OFFX-1:0]  offset;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             unused_bits;

    assign word_addr   = addr[ADDR_W-1:2];
    assign idx         = word_addr[OFF_W +: IDX_W];
    assign tag         = word_addr[OFF_W+IDX_W +: TAG_W];
    assign line_base   = word_addr & ~WA_W'(WORDS - 1);
    assign unused_bits = &{1'b0, addr[1:0]};

    if (OFF_W > 0) begin : g_off
        assign offset = word_addr[OFF_W-1:0];
    end else begin : g_nooff
        assign offset = '0;
    end

    state_e                          state;
    logic [CNT_W-1:0]                cnt;
    logic [LINES-1:0]                valid;
    logic [TAG_W-1:0]                tags [LINES];
    logic [WORDS-1:0][DATA_W-1:0]    cache_data [LINES];
    logic [WORDS-1:0][DATA_W-1:0]    rline;
    logic [DATA_W-1:0]               rdata_q, cached_word;
    logic                            hit, rd_hit, rd_miss, rd_live;

    assign hit         = valid[idx] && (tags[idx] == tag);
    assign cached_word = cache_data[idx][offset];
    // A store in the same cycle as a load wins; the load is dropped.
    assign rd_hit      = (state == IDLE) && rden && !wren && hit;
    assign rd_miss     = (state == IDLE) && rden && !wren && !hit;
    assign rd_live     = rd_hit || (state == DONE);
    assign stall       = rd_miss || (state == FILL);
    assign rdata       = rd_live ? cached_word : rdata_q;

    dmem_backing #(
        .DATA_W(DATA_W), .WA_W(WA_W), .WORDS(WORDS), .MEM_DEPTH(MEM_DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   ((state == IDLE) && wren),
        .waddr(word_addr),
        .wdata(wdata),
        .raddr(line_base),
        .rline(rline)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            valid   <= '0;
            rdata_q <= '0;
        end else begin
            if (rd_live) rdata_q <= cached_word;
            case (state)
                IDLE: begin
                    if (wren) begin
                        if (hit) cache_data[idx][offset] <= wdata;
                    end else if (rden && !hit) begin
                        state <= FILL;
                        cnt   <= CNT_W'(MEM_LAT - 1);
                    end
                end
                FILL: begin
                    if (cnt == '0) begin
                        cache_data[idx] <= rline;
                        tags[idx]       <= tag;
                        valid[idx]      <= 1'b1;
                        state           <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (rd_hit)  hit_cnt  <= hit_cnt + 1'b1;
            if (rd_miss) miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_memsys.sv
// Directed bench for dcache_memsys (default parameters, MEM_LAT = 4).
module tb_dcache_memsys;

    logic        clk = 1'b0;
    logic        rst, rden, wren;
    logic [31:0] addr, wdata, rdata;
    logic        stall;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dcache_memsys dut (
        .clk  (clk),
        .rst  (rst),
        .rden (rden),
        .wren (wren),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .stall(stall)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a load, count stalled cycles, check data once stall drops.
    task automatic do_load(input logic [31:0] a, input logic [31:0] exp,
                           input int exp_stall, input string tag);
        int n;
        @(posedge clk); #1;
        rden = 1'b1; addr = a;
        n = 0;
        @(negedge clk);
        while (stall && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_stall"}, 32'(n), 32'(exp_stall));
        chk({tag, "_data"}, rdata, exp);
        @(posedge clk); #1;
        rden = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input string tag);
        @(posedge clk); #1;
        wren = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        wren = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rden = 1'b0; wren = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
`ifdef DCACHE_STATS_EN
        chk("rst_hits", hit_cnt, 32'd0);
        chk("rst_miss", miss_cnt, 32'd0);
`endif

        // Preload backing memory; uncached stores do not allocate.
        do_store(32'h40, 32'hDEADBEEF, "pre40");
        do_store(32'h44, 32'h12345678, "pre44");
        do_store(32'hC0, 32'hA5A50001, "preC0");

        do_load(32'h40, 32'hDEADBEEF, 5, "cold40");
        do_load(32'h40, 32'hDEADBEEF, 0, "hit40");
        do_load(32'h44, 32'h12345678, 0, "hit44");

        do_store(32'h40, 32'hCAFEF00D, "st40");
        do_load(32'h40, 32'hCAFEF00D, 0, "rehit40");
        chk("mem40", dut.u_mem.mem[16], 32'hCAFEF00D);

        do_store(32'h100, 32'h0BADF00D, "st100");
        do_load(32'h100, 32'h0BADF00D, 5, "miss100");
        @(negedge clk);
        chk("hold", rdata, 32'h0BADF00D);

        do_load(32'hC0, 32'hA5A50001, 5, "confC0");
        do_load(32'h40, 32'hCAFEF00D, 5, "evict40");
`ifdef DCACHE_STATS_EN
        chk("seq_hits", hit_cnt, 32'd3);
        chk("seq_miss", miss_cnt, 32'd4);
`endif

        // Reset during the second FILL cycle of a miss on 0xC0.
        @(posedge clk); #1;
        rden = 1'b1; addr = 32'hC0;
        @(posedge clk);
        @(negedge clk);
        chk("fill1_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; rden = 1'b0;
        @(negedge clk);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
`ifdef DCACHE_STATS_EN
        chk("abort_hits", hit_cnt, 32'd0);
        chk("abort_miss", miss_cnt, 32'd0);
`endif
        do_load(32'hC0, 32'hA5A50001, 5, "reloadC0");
        do_load(32'h40, 32'hCAFEF00D, 5, "reload40");
`ifdef DCACHE_STATS_EN
        chk("end_hits", hit_cnt, 32'd0);
        chk("end_miss", miss_cnt, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
